// File: rtl/wbck_arb_pkg.sv
// Shared types and widths for the writeback arbiter.
// Latency: n/a (types only). Backpressure: n/a.
// Width defaults follow the core's architecture selection.
package wbck_arb_pkg;

`ifdef MYRISCV_ARCH_64
    localparam int XLEN = 64;
`else
    localparam int XLEN = 32;
`endif

    localparam int REG_AW         = 5;
    localparam int STARVE_MAX_DEF = 3;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LPIP = 2'd1,
        GNT_ALU  = 2'd2
    } grant_e;

    typedef struct packed {
        logic [REG_AW-1:0] rdidx;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // x0 is hardwired to zero, so writes to it are swallowed.
    function automatic logic is_x0(input logic [REG_AW-1:0] idx);
        return idx == '0;
    endfunction

endpackage

// File: rtl/wbck_arb_if.sv
// Writeback bundle: ALU and long-pipe result channels plus the regfile write port.
// Latency: n/a (wiring only). Backpressure: vld/rdy per producer channel.
// The slave modport is the arbiter side; master is the producer/regfile side.
interface wbck_arb_if;

    logic                                  alu2wb_vld;
    logic                                  alu2wb_rdy;
    logic [wbck_arb_pkg::XLEN-1:0]         alu2wb_data;
    logic [wbck_arb_pkg::REG_AW-1:0]       alu2wb_rdidx;

    logic                                  lpip2wb_vld;
    logic                                  lpip2wb_rdy;
    logic [wbck_arb_pkg::XLEN-1:0]         lpip2wb_data;
    logic [wbck_arb_pkg::REG_AW-1:0]       lpip2wb_rdidx;

    logic                                  rf_wen;
    logic [wbck_arb_pkg::REG_AW-1:0]       rf_widx;
    logic [wbck_arb_pkg::XLEN-1:0]         rf_wdata;

    modport slave (
        input  alu2wb_vld, alu2wb_data, alu2wb_rdidx,
        output alu2wb_rdy,
        input  lpip2wb_vld, lpip2wb_data, lpip2wb_rdidx,
        output lpip2wb_rdy,
        output rf_wen, rf_widx, rf_wdata
    );

    modport master (
        output alu2wb_vld, alu2wb_data, alu2wb_rdidx,
        input  alu2wb_rdy,
        output lpip2wb_vld, lpip2wb_data, lpip2wb_rdidx,
        input  lpip2wb_rdy,
        input  rf_wen, rf_widx, rf_wdata
    );

endinterface

// File: rtl/wbck_arb.sv
// Merges ALU and long-pipe writeback onto the single regfile write port; long pipe has priority.
// Latency: 1 cycle from accept to rf_wen. Rdy is combinational from both vld inputs and starve_cnt.
// Backpressure: the loser is held off; after STARVE_MAX consecutive losses the ALU is forced to win.
module wbck_arb
    import wbck_arb_pkg::*;
#(
    parameter int STARVE_MAX = wbck_arb_pkg::STARVE_MAX_DEF
) (
    input  logic      clk,
    input  logic      rst,
    wbck_arb_if.slave wb
);

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_cnt_nxt;
    logic              force_alu;
    grant_e            grant;
    wb_req_t           winner;

    logic              rf_wen_q;
    logic [REG_AW-1:0] rf_widx_q;
    logic [XLEN-1:0]   rf_wdata_q;

    // Grant never looks at payload, so producers may present data and vld together.
    always_comb begin
        force_alu = wb.alu2wb_vld && (starve_cnt == CNT_MAX);
        grant     = GNT_NONE;
        if (!rst) begin
            if (wb.lpip2wb_vld && !force_alu) begin
                grant = GNT_LPIP;
            end else if (wb.alu2wb_vld) begin
                grant = GNT_ALU;
            end
        end
    end

    assign wb.lpip2wb_rdy = (grant == GNT_LPIP);
    assign wb.alu2wb_rdy  = (grant == GNT_ALU);

    always_comb begin
        winner.rdidx = wb.alu2wb_rdidx;
        winner.data  = wb.alu2wb_data;
        if (grant == GNT_LPIP) begin
            winner.rdidx = wb.lpip2wb_rdidx;
            winner.data  = wb.lpip2wb_data;
        end
    end

    // Counts only losses of a waiting ALU; any ALU win or idle ALU restarts the count.
    always_comb begin
        starve_cnt_nxt = '0;
        if (wb.alu2wb_vld && (grant == GNT_LPIP)) begin
            starve_cnt_nxt = (starve_cnt == CNT_MAX) ? CNT_MAX : starve_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            rf_wen_q   <= 1'b0;
            rf_widx_q  <= '0;
            rf_wdata_q <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            if (grant != GNT_NONE) begin
                rf_wen_q   <= !is_x0(winner.rdidx);
                rf_widx_q  <= winner.rdidx;
                rf_wdata_q <= winner.data;
            end else begin
                rf_wen_q   <= 1'b0;
            end
        end
    end

    assign wb.rf_wen   = rf_wen_q;
    assign wb.rf_widx  = rf_widx_q;
    assign wb.rf_wdata = rf_wdata_q;

    a_one_grant: assert property (@(posedge clk) disable iff (rst)
        !(wb.alu2wb_rdy && wb.lpip2wb_rdy));

    a_no_x0_write: assert property (@(posedge clk) disable iff (rst)
        !(wb.rf_wen && (wb.rf_widx == '0)));

endmodule
